// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: three-phase issue/execute/writeback sequencer that owns the register file feeding a combinational ALU.
// Revision 1.0
`default_nettype none

module alu_issue_ctrl #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_op,
   input  logic [REG_AW-1:0] in_rd,
   input  logic [REG_AW-1:0] in_rs1,
   input  logic [REG_AW-1:0] in_rs2,
   output logic [1:0]        alu_op,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   input  logic [DATA_W-1:0] alu_result,
   output logic              wb_valid,
   output logic [REG_AW-1:0] wb_rd,
   output logic [DATA_W-1:0] wb_data,
   output logic              busy,
   input  logic              dbg_we,
   input  logic [REG_AW-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic [DATA_W-1:0] dbg_rdata
);

   localparam int NREG = 1 << REG_AW;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_WB   = 2'd2;

   logic [1:0]        state;
   logic [1:0]        op_q;
   logic [REG_AW-1:0] rd_q;
   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] b_q;
   logic [DATA_W-1:0] res_q;
   logic [DATA_W-1:0] rf [NREG];
   logic              accept;

   assign accept = in_valid && (state == S_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         op_q  <= '0;
         rd_q  <= '0;
         a_q   <= '0;
         b_q   <= '0;
         res_q <= '0;
         for (int i = 0; i < NREG; i++) begin
            rf[i] <= '0;
         end
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  op_q  <= in_op;
                  rd_q  <= in_rd;
                  // Nonblocking reads see pre-edge contents, so a same-edge debug write is invisible here.
                  a_q   <= rf[in_rs1];
                  b_q   <= rf[in_rs2];
                  state <= S_EXEC;
               end
            end
            S_EXEC: begin
               res_q <= alu_result;
               state <= S_WB;
            end
            S_WB: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase

         if (dbg_we && (dbg_addr != '0)) begin
            rf[dbg_addr] <= dbg_wdata;
         end
         // Placed after the debug write so writeback wins on a same-register collision.
         if ((state == S_WB) && (rd_q != '0)) begin
            rf[rd_q] <= res_q;
         end
      end
   end

   assign in_ready  = (state == S_IDLE);
   assign busy      = (state != S_IDLE);
   assign alu_op    = (state == S_EXEC) ? op_q : 2'b00;
   assign alu_a     = (state == S_EXEC) ? a_q  : '0;
   assign alu_b     = (state == S_EXEC) ? b_q  : '0;
   assign wb_valid  = (state == S_WB);
   assign wb_rd     = (state == S_WB) ? rd_q  : '0;
   assign wb_data   = (state == S_WB) ? res_q : '0;
   assign dbg_rdata = (dbg_addr == '0) ? '0 : rf[dbg_addr];

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed stimulus with a writeback scoreboard checked by an independent monitor.
// Revision 1.0
`default_nettype none

module tb_alu_issue_ctrl;

   localparam int DATA_W = 32;
   localparam int REG_AW = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [1:0]        in_op = 2'b00;
   logic [REG_AW-1:0] in_rd = '0;
   logic [REG_AW-1:0] in_rs1 = '0;
   logic [REG_AW-1:0] in_rs2 = '0;
   logic [1:0]        alu_op;
   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   logic [DATA_W-1:0] alu_result;
   logic              wb_valid;
   logic [REG_AW-1:0] wb_rd;
   logic [DATA_W-1:0] wb_data;
   logic              busy;
   logic              dbg_we = 1'b0;
   logic [REG_AW-1:0] dbg_addr = '0;
   logic [DATA_W-1:0] dbg_wdata = '0;
   logic [DATA_W-1:0] dbg_rdata;

   int total = 0;
   int bad   = 0;
   logic [REG_AW+DATA_W-1:0] exp_q [$];

   always #5 clk = ~clk;

   // Stand-in for the external ALU.
   always_comb begin
      case (alu_op)
         2'b01:   alu_result = alu_a + alu_b;
         2'b10:   alu_result = alu_a - alu_b;
         2'b11:   alu_result = alu_a * alu_b;
         default: alu_result = '0;
      endcase
   end

   alu_issue_ctrl #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .busy(busy),
      .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every writeback pulse must match the oldest expected entry.
   always @(negedge clk) begin
      if (!rst && wb_valid) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL wb_unexpected: got rd=%0d data=0x%0h expected no writeback", wb_rd, wb_data);
         end else begin
            logic [REG_AW+DATA_W-1:0] e;
            e = exp_q.pop_front();
            if ({wb_rd, wb_data} !== e) begin
               bad++;
               $display("FAIL wb: got rd=%0d data=0x%0h expected rd=%0d data=0x%0h",
                        wb_rd, wb_data, e[REG_AW+DATA_W-1:DATA_W], e[DATA_W-1:0]);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic dbg_write(input logic [REG_AW-1:0] a, input logic [DATA_W-1:0] d);
      dbg_we = 1'b1; dbg_addr = a; dbg_wdata = d;
      step();
      dbg_we = 1'b0;
   endtask

   task automatic dbg_check(input string name, input logic [REG_AW-1:0] a, input logic [DATA_W-1:0] d);
      dbg_addr = a;
      #1;
      check(name, 64'(dbg_rdata), 64'(d));
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!in_ready && n < 20) begin
         step();
         n++;
      end
      check("ready_timeout", 64'(in_ready), 64'd1);
   endtask

   // Accept one instruction, check the EXEC-cycle ALU drive, then let it retire.
   task automatic issue(input logic [1:0] op, input logic [REG_AW-1:0] rd, rs1, rs2,
                        input logic [DATA_W-1:0] ea, eb, ed);
      wait_ready();
      in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
      exp_q.push_back({rd, ed});
      step();
      in_valid = 1'b0;
      check("exec_op", 64'(alu_op), 64'(op));
      check("exec_a", 64'(alu_a), 64'(ea));
      check("exec_b", 64'(alu_b), 64'(eb));
      check("exec_ready", 64'(in_ready), 64'd0);
      step();
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // 1: reset state
      rst = 1'b1;
      step(); step();
      check("rst_ready", 64'(in_ready), 64'd1);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_wb_valid", 64'(wb_valid), 64'd0);
      check("rst_alu_op", 64'(alu_op), 64'd0);
      check("rst_alu_a", 64'(alu_a), 64'd0);
      for (int i = 0; i < 16; i++) dbg_check("rst_rf", 4'(i), 32'd0);
      rst = 1'b0;
      step();

      // 2: ADD
      dbg_write(4'd1, 32'd5);
      dbg_write(4'd2, 32'd3);
      issue(2'b01, 4'd3, 4'd1, 4'd2, 32'd5, 32'd3, 32'd8);
      dbg_check("r3_after_add", 4'd3, 32'd8);

      // 3: SUB wrap, MUL truncation, ZERO
      issue(2'b10, 4'd4, 4'd2, 4'd1, 32'd3, 32'd5, 32'hFFFF_FFFE);
      dbg_check("r4_after_sub", 4'd4, 32'hFFFF_FFFE);
      dbg_write(4'd5, 32'h0001_0000);
      dbg_write(4'd6, 32'h0001_0000);
      issue(2'b11, 4'd8, 4'd5, 4'd6, 32'h0001_0000, 32'h0001_0000, 32'd0);
      issue(2'b00, 4'd9, 4'd1, 4'd2, 32'd5, 32'd3, 32'd0);

      // 4: writes to r0 are discarded
      issue(2'b01, 4'd0, 4'd1, 4'd2, 32'd5, 32'd3, 32'd8);
      dbg_check("r0_after_wb", 4'd0, 32'd0);
      dbg_write(4'd0, 32'h1234);
      dbg_check("r0_after_dbg", 4'd0, 32'd0);

      // 5: back-to-back with in_valid held high; dependent read
      in_valid = 1'b1; in_op = 2'b01; in_rd = 4'd3; in_rs1 = 4'd1; in_rs2 = 4'd2;
      exp_q.push_back({4'd3, 32'd8});
      step();
      in_rd = 4'd7; in_rs1 = 4'd3; in_rs2 = 4'd3;
      exp_q.push_back({4'd7, 32'd16});
      check("b2b_ready_exec", 64'(in_ready), 64'd0);
      step();
      check("b2b_ready_wb", 64'(in_ready), 64'd0);
      step();
      check("b2b_ready_idle", 64'(in_ready), 64'd1);
      step();
      in_valid = 1'b0;
      check("b2b_second_a", 64'(alu_a), 64'd8);
      check("b2b_second_b", 64'(alu_b), 64'd8);
      step(); step();
      dbg_check("r7_after_b2b", 4'd7, 32'd16);

      // 6a: reset during EXEC drops the instruction and clears the regfile
      in_valid = 1'b1; in_op = 2'b01; in_rd = 4'd10; in_rs1 = 4'd1; in_rs2 = 4'd2;
      step();
      in_valid = 1'b0;
      check("pre_rst_busy", 64'(busy), 64'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("post_rst_ready", 64'(in_ready), 64'd1);
      check("post_rst_wb", 64'(wb_valid), 64'd0);
      for (int i = 0; i < 16; i++) dbg_check("post_rst_rf", 4'(i), 32'd0);
      step();
      check("post_rst_wb2", 64'(wb_valid), 64'd0);

      // 6b: WB and debug write to r3 on the same edge; WB wins
      dbg_write(4'd1, 32'd5);
      dbg_write(4'd2, 32'd3);
      in_valid = 1'b1; in_op = 2'b01; in_rd = 4'd3; in_rs1 = 4'd1; in_rs2 = 4'd2;
      exp_q.push_back({4'd3, 32'd8});
      step();
      in_valid = 1'b0;
      step();
      check("collide_in_wb", 64'(wb_valid), 64'd1);
      dbg_write(4'd3, 32'hDEAD);
      dbg_check("collide_r3", 4'd3, 32'd8);

      step();
      check("sb_drained", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
